ace_snoop_initiator: RTL and testbench
======================================

Name: ace_snoop_initiator

Overview:
- Interconnect-side ACE snoop master: issues AC-channel snoop requests across a programmed address range, one cache line at a time.
- Consumes the CR response and any CD data beats, then reports counts, worst-case response latency and protocol errors.
- Used as the traffic source and checker facing the snoop responder, in simulation and on-FPGA self-test.

Parameters:
- C_ACE_ADDR_WIDTH, 44, AC address width
- C_ACE_DATA_WIDTH, 128, CD data width; must divide LINE_BYTES*8
- LINE_BYTES, 64, cache-line size and snoop address stride
- CNT_WIDTH, 16, width of the snoop and data counters

Ports:
- ace_aclk  in  1  clock
- ace_areset  in  1  synchronous reset, active-high
- i_start  in  1  one-cycle pulse; starts a sequence
- i_acsnoop  in  4  ACSNOOP code used for every snoop
- i_base_addr  in  C_ACE_ADDR_WIDTH  first address; aligned down to LINE_BYTES
- i_addr_size  in  32  range size in bytes
- i_timeout  in  32  maximum cycles in CR_WAIT or CD_WAIT; 0 disables the timeout
- o_acvalid  out  1  AC valid
- i_acready  in  1  AC ready
- o_acaddr  out  C_ACE_ADDR_WIDTH  snoop address
- o_acsnoop  out  4  snoop type
- o_acprot  out  3  fixed 3'b010
- i_crvalid  in  1  CR valid
- o_crready  out  1  CR ready
- i_crresp  in  5  CRRESP[4:0]
- i_cdvalid  in  1  CD valid
- o_cdready  out  1  CD ready
- i_cddata  in  C_ACE_DATA_WIDTH  CD data
- i_cdlast  in  1  CD last
- o_busy  out  1  sequence in progress
- o_done  out  1  one-cycle pulse on normal completion
- o_snoop_count  out  CNT_WIDTH  completed CR handshakes
- o_data_count  out  CNT_WIDTH  CD beats accepted
- o_max_latency  out  32  worst case, in cycles, from AC handshake to CR handshake
- o_err_timeout  out  1  sticky
- o_err_cdlast  out  1  sticky
- o_err_crresp  out  1  sticky; set when CRRESP[1] (Error) is seen
- o_checksum  out  C_ACE_DATA_WIDTH  see Optional Feature

Behaviour:
- Reset: every output is 0; FSM goes to IDLE.
  - A reset asserted mid-sequence aborts on that same edge: o_acvalid drops, o_done does not pulse.
- BEATS = LINE_BYTES*8/C_ACE_DATA_WIDTH (4 with the defaults).
- NLINES = ceil(i_addr_size/LINE_BYTES).
- States: IDLE, AC_REQ, CR_WAIT, CD_WAIT, NEXT, ERR.
- IDLE:
  - On i_start, latch all inputs.
  - Clear counters, errors, max latency and checksum.
  - Set o_busy.
  - If NLINES==0: pulse o_done next cycle and stay in IDLE.
  - Otherwise go to AC_REQ.
- i_start while o_busy=1 is ignored.
- AC_REQ:
  - o_acvalid=1; o_acaddr, o_acsnoop and o_acprot are held stable until the handshake.
  - On acvalid&acready go to CR_WAIT; the latency counter is cleared to 0.
- CR_WAIT:
  - o_crready=1; the latency counter increments each cycle.
  - On the CR handshake:
    - o_snoop_count increments.
    - o_max_latency = max(o_max_latency, latency+1).
    - CRRESP[1] sets o_err_crresp.
    - If CRRESP[0] (DataTransfer) = 1, go to CD_WAIT; otherwise go to NEXT.
  - Same-cycle AC and CR handshakes are impossible: CR is accepted only from the cycle after the AC handshake.
- CD_WAIT:
  - o_cdready=1; each accepted beat increments o_data_count and the beat index.
  - The burst ends on whichever comes first: cdlast, or beat index reaching BEATS.
    - If cdlast arrives on a beat other than BEATS, set o_err_cdlast.
    - If beat BEATS arrives without cdlast, set o_err_cdlast.
  - When the burst ends, go to NEXT.
- NEXT (one cycle):
  - Address += LINE_BYTES, wrapping modulo 2^C_ACE_ADDR_WIDTH.
  - If the line count reaches NLINES: clear o_busy, pulse o_done, go to IDLE.
  - Otherwise go to AC_REQ.
- Timeout:
  - A wait counter clears on entry to CR_WAIT and to CD_WAIT.
  - If i_timeout!=0 and the counter reaches i_timeout, set o_err_timeout and go to ERR.
- ERR:
  - Deassert all ready/valid outputs, clear o_busy, go to IDLE; o_done does not pulse.
- Counters saturate at all-ones.
- Outputs are registered; o_acvalid rises the cycle after i_start.

Optional Feature:
- Macro: ACE_SNOOP_INIT_CHECKSUM_EN.
- Defined: o_checksum = XOR of every accepted i_cddata beat since i_start.
- Undefined: o_checksum is tied to 0 and no accumulator is built.

Test Plan:
- Scenario 1 (range without data):
  - Stimulus: base 0x1000, size 256, acsnoop 4'b0001, responder returns crresp 0 after 3 cycles.
  - Response: 4 snoops at 0x1000/0x1040/0x1080/0x10C0, snoop_count=4, data_count=0, max_latency=3, one o_done pulse.
- Scenario 2 (range with data):
  - Stimulus: size 128, responder returns crresp 5'b00101, then 4 beats with cdlast on beat 4.
  - Response: data_count=8, no errors, checksum = XOR of the 8 beats (macro defined).
- Scenario 3 (cdlast errors):
  - Stimulus: cdlast on beat 2; separately, no cdlast on beat 4.
  - Response: o_err_cdlast=1 in both cases, sequence completes, o_done pulses.
- Scenario 4 (timeout):
  - Stimulus: i_timeout=10, responder never asserts crvalid.
  - Response: o_err_timeout=1, o_busy=0, no o_done; the next i_start clears the error.
- Scenario 5 (edge cases):
  - Stimulus: size 0; i_start pulsed while busy; base 0xFFF_FFFF_FFC0 with size 128.
  - Response: o_done pulses with snoop_count=0; the extra start is ignored; the second snoop wraps to address 0.
- Scenario 6 (reset mid-burst):
  - Stimulus: ace_areset asserted during CD_WAIT.
  - Response: all outputs are 0 the next cycle, FSM in IDLE, no o_done.

Source files
------------

// File: rtl/ace_snoop_initiator.sv
// rtl/ace_snoop_initiator.sv - ACE snoop master sweeping an address range one cache line at a time
//
// Purpose: issues one AC snoop per cache line across [base, base+size), accepts the CR
// response and any CD data burst, and reports counts, worst-case AC->CR latency and
// sticky protocol errors.
//
// Ports:
//   ace_aclk, ace_areset                                  clock, synchronous active-high reset
//   i_start, i_acsnoop, i_base_addr, i_addr_size, i_timeout   sequence setup, latched on i_start
//   o_acvalid, i_acready, o_acaddr, o_acsnoop, o_acprot   AC channel
//   i_crvalid, o_crready, i_crresp                        CR channel
//   i_cdvalid, o_cdready, i_cddata, i_cdlast              CD channel
//   o_busy, o_done                                        sequence status
//   o_snoop_count, o_data_count, o_max_latency            statistics
//   o_err_timeout, o_err_cdlast, o_err_crresp             sticky errors
//   o_checksum                                            XOR of accepted CD beats
//
// Build option: ACE_SNOOP_INIT_CHECKSUM_EN builds the CD checksum accumulator;
// without it o_checksum is tied to zero.

module ace_snoop_initiator #(
   parameter int C_ACE_ADDR_WIDTH = 44,
   parameter int C_ACE_DATA_WIDTH = 128,
   parameter int LINE_BYTES       = 64,
   parameter int CNT_WIDTH        = 16
) (
   input  logic                        ace_aclk,
   input  logic                        ace_areset,
   input  logic                        i_start,
   input  logic [3:0]                  i_acsnoop,
   input  logic [C_ACE_ADDR_WIDTH-1:0] i_base_addr,
   input  logic [31:0]                 i_addr_size,
   input  logic [31:0]                 i_timeout,
   output logic                        o_acvalid,
   input  logic                        i_acready,
   output logic [C_ACE_ADDR_WIDTH-1:0] o_acaddr,
   output logic [3:0]                  o_acsnoop,
   output logic [2:0]                  o_acprot,
   input  logic                        i_crvalid,
   output logic                        o_crready,
   input  logic [4:0]                  i_crresp,
   input  logic                        i_cdvalid,
   output logic                        o_cdready,
   input  logic [C_ACE_DATA_WIDTH-1:0] i_cddata,
   input  logic                        i_cdlast,
   output logic                        o_busy,
   output logic                        o_done,
   output logic [CNT_WIDTH-1:0]        o_snoop_count,
   output logic [CNT_WIDTH-1:0]        o_data_count,
   output logic [31:0]                 o_max_latency,
   output logic                        o_err_timeout,
   output logic                        o_err_cdlast,
   output logic                        o_err_crresp,
   output logic [C_ACE_DATA_WIDTH-1:0] o_checksum
);

   localparam int AW     = C_ACE_ADDR_WIDTH;
   localparam int BEATS  = LINE_BYTES * 8 / C_ACE_DATA_WIDTH;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [2:0] {S_IDLE, S_AC_REQ, S_CR_WAIT, S_CD_WAIT, S_NEXT, S_ERR} state_t;

   state_t               r_state, w_next;
   logic                 r_acvalid, r_crready, r_cdready, r_busy, r_done;
   logic [2:0]           r_acprot;
   logic [AW-1:0]        r_addr;
   logic [3:0]           r_acsnoop;
   logic [CNT_WIDTH-1:0] r_snoop_count, r_data_count;
   logic [31:0]          r_max_latency, r_timeout, r_wait;
   logic                 r_err_timeout, r_err_cdlast, r_err_crresp;
   logic [32:0]          r_nlines, r_line_cnt;
   logic [BEAT_W-1:0]    r_beat;

   logic        w_ac_hs, w_cr_hs, w_cd_hs, w_tmo, w_last_beat, w_burst_end, w_last_line;
   logic [32:0] w_nlines;
   logic [31:0] w_lat;
   logic        w_unused_crresp;

   // 33-bit sum so a size near 2^32 cannot overflow the round-up.
   assign w_nlines    = ({1'b0, i_addr_size} + 33'(LINE_BYTES - 1)) / 33'(LINE_BYTES);
   assign w_ac_hs     = r_acvalid & i_acready;
   assign w_cr_hs     = r_crready & i_crvalid;
   assign w_cd_hs     = r_cdready & i_cdvalid;
   // r_wait counts cycles already spent in the state; this is the cycle it reaches the limit.
   assign w_tmo       = (r_timeout != 32'd0) && (r_wait + 32'd1 == r_timeout);
   assign w_last_beat = (r_beat == BEAT_W'(BEATS - 1));
   assign w_burst_end = w_cd_hs && (i_cdlast || w_last_beat);
   assign w_last_line = (r_line_cnt + 33'd1 == r_nlines);
   assign w_lat       = r_wait + 32'd1;
   assign w_unused_crresp = ^i_crresp[4:2];

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (i_start && w_nlines != 33'd0) w_next = S_AC_REQ;
         S_AC_REQ:  if (w_ac_hs) w_next = S_CR_WAIT;
         S_CR_WAIT: begin
            if (w_cr_hs)    w_next = i_crresp[0] ? S_CD_WAIT : S_NEXT;
            else if (w_tmo) w_next = S_ERR;
         end
         S_CD_WAIT: begin
            if (w_burst_end) w_next = S_NEXT;
            else if (w_tmo)  w_next = S_ERR;
         end
         S_NEXT:    w_next = w_last_line ? S_IDLE : S_AC_REQ;
         S_ERR:     w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge ace_aclk) begin
      if (ace_areset) begin
         r_state       <= S_IDLE;
         r_acvalid     <= 1'b0;
         r_acprot      <= 3'b000;
         r_crready     <= 1'b0;
         r_cdready     <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_addr        <= '0;
         r_acsnoop     <= 4'd0;
         r_snoop_count <= '0;
         r_data_count  <= '0;
         r_max_latency <= 32'd0;
         r_timeout     <= 32'd0;
         r_wait        <= 32'd0;
         r_err_timeout <= 1'b0;
         r_err_cdlast  <= 1'b0;
         r_err_crresp  <= 1'b0;
         r_nlines      <= 33'd0;
         r_line_cnt    <= 33'd0;
         r_beat        <= '0;
      end else begin
         r_state   <= w_next;
         // Handshake outputs are registered copies of the next-state decode.
         r_acvalid <= (w_next == S_AC_REQ);
         r_acprot  <= (w_next == S_AC_REQ) ? 3'b010 : 3'b000;
         r_crready <= (w_next == S_CR_WAIT);
         r_cdready <= (w_next == S_CD_WAIT);
         r_busy    <= (w_next == S_AC_REQ) || (w_next == S_CR_WAIT) ||
                      (w_next == S_CD_WAIT) || (w_next == S_NEXT);
         r_done    <= 1'b0;
         case (r_state)
            S_IDLE: if (i_start) begin
               r_addr        <= i_base_addr & ~AW'(LINE_BYTES - 1);
               r_acsnoop     <= i_acsnoop;
               r_timeout     <= i_timeout;
               r_nlines      <= w_nlines;
               r_line_cnt    <= 33'd0;
               r_snoop_count <= '0;
               r_data_count  <= '0;
               r_max_latency <= 32'd0;
               r_err_timeout <= 1'b0;
               r_err_cdlast  <= 1'b0;
               r_err_crresp  <= 1'b0;
               r_done        <= (w_nlines == 33'd0);
            end
            S_AC_REQ: if (w_ac_hs) r_wait <= 32'd0;
            S_CR_WAIT: begin
               r_wait <= r_wait + 32'd1;
               if (w_cr_hs) begin
                  if (r_snoop_count != '1) r_snoop_count <= r_snoop_count + CNT_WIDTH'(1);
                  if (w_lat > r_max_latency) r_max_latency <= w_lat;
                  if (i_crresp[1]) r_err_crresp <= 1'b1;
                  r_wait <= 32'd0;
                  r_beat <= '0;
               end else if (w_tmo) begin
                  r_err_timeout <= 1'b1;
               end
            end
            S_CD_WAIT: begin
               r_wait <= r_wait + 32'd1;
               if (w_cd_hs) begin
                  if (r_data_count != '1) r_data_count <= r_data_count + CNT_WIDTH'(1);
                  r_beat <= r_beat + BEAT_W'(1);
                  // cdlast must coincide exactly with the final beat of the line.
                  if (i_cdlast != w_last_beat) r_err_cdlast <= 1'b1;
               end
               if (!w_burst_end && w_tmo) r_err_timeout <= 1'b1;
            end
            S_NEXT: begin
               r_addr     <= r_addr + AW'(LINE_BYTES);
               r_line_cnt <= r_line_cnt + 33'd1;
               r_done     <= w_last_line;
            end
            default: ;
         endcase
      end
   end

`ifdef ACE_SNOOP_INIT_CHECKSUM_EN
   logic [C_ACE_DATA_WIDTH-1:0] r_checksum;
   always_ff @(posedge ace_aclk) begin
      if (ace_areset)                     r_checksum <= '0;
      else if (r_state == S_IDLE && i_start) r_checksum <= '0;
      else if (w_cd_hs)                   r_checksum <= r_checksum ^ i_cddata;
   end
   assign o_checksum = r_checksum;
`else
   logic w_unused_cddata;
   assign w_unused_cddata = ^i_cddata;
   assign o_checksum      = '0;
`endif

   assign o_acvalid     = r_acvalid;
   assign o_acaddr      = r_addr;
   assign o_acsnoop     = r_acsnoop;
   assign o_acprot      = r_acprot;
   assign o_crready     = r_crready;
   assign o_cdready     = r_cdready;
   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_snoop_count = r_snoop_count;
   assign o_data_count  = r_data_count;
   assign o_max_latency = r_max_latency;
   assign o_err_timeout = r_err_timeout;
   assign o_err_cdlast  = r_err_cdlast;
   assign o_err_crresp  = r_err_crresp;

endmodule

// File: tb/tb_ace_snoop_initiator.sv
// tb/tb_ace_snoop_initiator.sv - table-driven bench for ace_snoop_initiator

module tb_ace_snoop_initiator;

   localparam int AW    = 44;
   localparam int DW    = 128;
   localparam int LB    = 64;
   localparam int CW    = 16;
   localparam int BEATS = LB * 8 / DW;

   logic          clk;
   logic          ace_areset;
   logic          i_start;
   logic [3:0]    i_acsnoop;
   logic [AW-1:0] i_base_addr;
   logic [31:0]   i_addr_size;
   logic [31:0]   i_timeout;
   logic          o_acvalid;
   logic          i_acready;
   logic [AW-1:0] o_acaddr;
   logic [3:0]    o_acsnoop;
   logic [2:0]    o_acprot;
   logic          i_crvalid;
   logic          o_crready;
   logic [4:0]    i_crresp;
   logic          i_cdvalid;
   logic          o_cdready;
   logic [DW-1:0] i_cddata;
   logic          i_cdlast;
   logic          o_busy;
   logic          o_done;
   logic [CW-1:0] o_snoop_count;
   logic [CW-1:0] o_data_count;
   logic [31:0]   o_max_latency;
   logic          o_err_timeout;
   logic          o_err_cdlast;
   logic          o_err_crresp;
   logic [DW-1:0] o_checksum;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;

   ace_snoop_initiator #(
      .C_ACE_ADDR_WIDTH(AW), .C_ACE_DATA_WIDTH(DW), .LINE_BYTES(LB), .CNT_WIDTH(CW)
   ) dut (
      .ace_aclk(clk), .ace_areset(ace_areset), .i_start(i_start), .i_acsnoop(i_acsnoop),
      .i_base_addr(i_base_addr), .i_addr_size(i_addr_size), .i_timeout(i_timeout),
      .o_acvalid(o_acvalid), .i_acready(i_acready), .o_acaddr(o_acaddr),
      .o_acsnoop(o_acsnoop), .o_acprot(o_acprot), .i_crvalid(i_crvalid),
      .o_crready(o_crready), .i_crresp(i_crresp), .i_cdvalid(i_cdvalid),
      .o_cdready(o_cdready), .i_cddata(i_cddata), .i_cdlast(i_cdlast), .o_busy(o_busy),
      .o_done(o_done), .o_snoop_count(o_snoop_count), .o_data_count(o_data_count),
      .o_max_latency(o_max_latency), .o_err_timeout(o_err_timeout),
      .o_err_cdlast(o_err_cdlast), .o_err_crresp(o_err_crresp), .o_checksum(o_checksum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (o_done) done_cnt = done_cnt + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [AW-1:0] base;
      logic [31:0]   size;
      logic [3:0]    snoop;
      logic [31:0]   tmo;
      int            cr_dly;     // cycles from AC handshake to CR handshake; 0 = never respond
      int            lat_step;   // extra CR delay added per line
      logic [4:0]    crresp;
      int            last_beat;  // beat carrying cdlast; 0 = cdlast never asserted
      int            exp_snoops;
      int            exp_beats;
      int            exp_maxlat;
      logic          exp_tmo;
      logic          exp_cdl;
      logic          exp_crr;
      int            exp_done;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic string nm(input int idx, input string s);
      return $sformatf("v%0d_%s", idx, s);
   endfunction

   function automatic logic [DW-1:0] beat_data(input int ln, input int b);
      logic [31:0] k;
      k = 32'(ln * 8 + b);
      return {32'hC0DE_0000 ^ k, ~k, 32'h1234_5678 + k, k << 3};
   endfunction

   task automatic wait_ac(input string name);
      int t;
      t = 0;
      while (!o_acvalid && t < 20) begin @(negedge clk); t++; end
      check(name, 128'(o_acvalid), 128'(1));
   endtask

   task automatic wait_idle(input string name);
      int t;
      t = 0;
      while (o_busy && t < 80) begin @(negedge clk); t++; end
      check(name, 128'(o_busy), 128'(0));
      @(negedge clk);
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      logic [AW-1:0] a;
      logic [DW-1:0] csum, d;
      int d0, n_ac, dly, nb;
      a    = v.base & ~AW'(LB - 1);
      csum = '0;
      d0   = done_cnt;
      i_base_addr = v.base;
      i_addr_size = v.size;
      i_acsnoop   = v.snoop;
      i_timeout   = v.tmo;
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      @(negedge clk);
      n_ac = (v.cr_dly == 0) ? 1 : v.exp_snoops;
      check(nm(idx, "acvalid_rise"), 128'(o_acvalid), 128'(n_ac != 0));
      for (int ln = 0; ln < n_ac; ln++) begin
         wait_ac(nm(idx, "ac_wait"));
         check(nm(idx, "acaddr"), 128'(o_acaddr), 128'(a));
         check(nm(idx, "acprot_snoop"), 128'({o_acprot, o_acsnoop}), 128'({3'b010, v.snoop}));
         i_acready = 1'b1;
         @(negedge clk);
         i_acready = 1'b0;
         if (v.cr_dly != 0) begin
            dly = v.cr_dly + ln * v.lat_step;
            repeat (dly - 1) @(negedge clk);
            i_crvalid = 1'b1;
            i_crresp  = v.crresp;
            @(negedge clk);
            i_crvalid = 1'b0;
            i_crresp  = 5'd0;
            if (v.crresp[0]) begin
               nb = (v.last_beat == 0) ? BEATS : v.last_beat;
               for (int b = 0; b < nb; b++) begin
                  d = beat_data(ln, b);
                  csum = csum ^ d;
                  i_cdvalid = 1'b1;
                  i_cddata  = d;
                  i_cdlast  = (b + 1 == v.last_beat);
                  @(negedge clk);
               end
               i_cdvalid = 1'b0;
               i_cdlast  = 1'b0;
            end
         end
         a = a + AW'(LB);
      end
      wait_idle(nm(idx, "idle_wait"));
      check(nm(idx, "snoop_count"), 128'(o_snoop_count), 128'(v.exp_snoops));
      check(nm(idx, "data_count"), 128'(o_data_count), 128'(v.exp_beats));
      check(nm(idx, "max_latency"), 128'(o_max_latency), 128'(v.exp_maxlat));
      check(nm(idx, "errors"), 128'({o_err_timeout, o_err_cdlast, o_err_crresp}),
            128'({v.exp_tmo, v.exp_cdl, v.exp_crr}));
      check(nm(idx, "done_pulses"), 128'(done_cnt - d0), 128'(v.exp_done));
      check(nm(idx, "handshake_idle"), 128'({o_acvalid, o_crready, o_cdready}), 128'(0));
`ifdef ACE_SNOOP_INIT_CHECKSUM_EN
      check(nm(idx, "checksum"), 128'(o_checksum), 128'(csum));
`else
      check(nm(idx, "checksum"), 128'(o_checksum), 128'(0));
`endif
   endtask

   initial begin
      int d0;
      vecs[0] = '{44'h1000, 32'd256, 4'b0001, 32'd0, 3, 0, 5'b00000, 4, 4, 0, 3, 1'b0, 1'b0, 1'b0, 1};
      vecs[1] = '{44'h4000, 32'd128, 4'b0111, 32'd0, 1, 0, 5'b00101, 4, 2, 8, 1, 1'b0, 1'b0, 1'b0, 1};
      vecs[2] = '{44'h8000, 32'd64, 4'b1001, 32'd5, 2, 0, 5'b00001, 2, 1, 2, 2, 1'b0, 1'b1, 1'b0, 1};
      vecs[3] = '{44'h8040, 32'd64, 4'b1001, 32'd0, 1, 0, 5'b00001, 0, 1, 4, 1, 1'b0, 1'b1, 1'b0, 1};
      vecs[4] = '{44'hA000, 32'd64, 4'b0001, 32'd10, 0, 0, 5'b00000, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0, 0};
      vecs[5] = '{44'h2010, 32'd65, 4'b0010, 32'd0, 2, 1, 5'b00010, 0, 2, 0, 3, 1'b0, 1'b0, 1'b1, 1};
      vecs[6] = '{44'h3000, 32'd0, 4'b0001, 32'd0, 1, 0, 5'b00000, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1};
      vecs[7] = '{44'hFFF_FFFF_FFC0, 32'd128, 4'b0001, 32'd0, 1, 0, 5'b00000, 0, 2, 0, 1, 1'b0, 1'b0, 1'b0, 1};

      ace_areset = 1'b1;
      i_start = 1'b0; i_acsnoop = 4'd0; i_base_addr = '0; i_addr_size = 32'd0; i_timeout = 32'd0;
      i_acready = 1'b0; i_crvalid = 1'b0; i_crresp = 5'd0;
      i_cdvalid = 1'b0; i_cddata = '0; i_cdlast = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_ctrl", 128'({o_acvalid, o_crready, o_cdready, o_busy, o_done, o_acprot, o_acsnoop}), 128'(0));
      check("reset_stats", 128'({o_snoop_count, o_data_count, o_max_latency, o_acaddr}), 128'(0));
      check("reset_errs", 128'({o_err_timeout, o_err_cdlast, o_err_crresp}), 128'(0));
      ace_areset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

      // Start pulsed while busy must not disturb the running sequence.
      d0 = done_cnt;
      i_base_addr = 44'h3000; i_addr_size = 32'd128; i_acsnoop = 4'b1000; i_timeout = 32'd0;
      i_start = 1'b1; @(negedge clk); i_start = 1'b0;
      wait_ac("busy_ac0_wait");
      check("busy_ac0_addr", 128'(o_acaddr), 128'(44'h3000));
      i_acready = 1'b1; @(negedge clk); i_acready = 1'b0;
      i_base_addr = 44'h9000; i_addr_size = 32'd0; i_acsnoop = 4'b0010;
      i_start = 1'b1; @(negedge clk); i_start = 1'b0;
      i_crvalid = 1'b1; @(negedge clk); i_crvalid = 1'b0;
      wait_ac("busy_ac1_wait");
      check("busy_ac1_addr", 128'(o_acaddr), 128'(44'h3040));
      check("busy_ac1_snoop", 128'(o_acsnoop), 128'(4'b1000));
      i_acready = 1'b1; @(negedge clk); i_acready = 1'b0;
      i_crvalid = 1'b1; @(negedge clk); i_crvalid = 1'b0;
      wait_idle("busy_idle_wait");
      check("busy_snoop_count", 128'(o_snoop_count), 128'(2));
      check("busy_max_latency", 128'(o_max_latency), 128'(2));
      check("busy_done_pulses", 128'(done_cnt - d0), 128'(1));

      // Reset in the middle of a CD burst.
      d0 = done_cnt;
      i_base_addr = 44'h5000; i_addr_size = 32'd64; i_acsnoop = 4'b0001;
      i_start = 1'b1; @(negedge clk); i_start = 1'b0;
      wait_ac("rst_ac_wait");
      i_acready = 1'b1; @(negedge clk); i_acready = 1'b0;
      i_crvalid = 1'b1; i_crresp = 5'b00001; @(negedge clk); i_crvalid = 1'b0; i_crresp = 5'd0;
      check("rst_cdready_before", 128'(o_cdready), 128'(1));
      i_cdvalid = 1'b1; i_cddata = beat_data(9, 0); @(negedge clk);
      ace_areset = 1'b1; @(negedge clk);
      check("rst_mid_ctrl", 128'({o_acvalid, o_crready, o_cdready, o_busy, o_done}), 128'(0));
      check("rst_mid_stats", 128'({o_snoop_count, o_data_count, o_max_latency}), 128'(0));
      check("rst_mid_addr", 128'(o_acaddr), 128'(0));
      check("rst_mid_checksum", 128'(o_checksum), 128'(0));
      i_cdvalid = 1'b0;
      ace_areset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_mid_stays_idle", 128'({o_busy, o_acvalid}), 128'(0));
      check("rst_mid_no_done", 128'(done_cnt - d0), 128'(0));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
